mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: turns load/store requests into a single-beat bus transaction and extends load data.
// Optional MEM_TIMEOUT_EN adds an 8-bit REQ watchdog that aborts the access with a Bus_err pulse.
module mem_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        Mem_read,
    input  logic        Mem_write,
    input  logic [5:0]  Exe_opcode,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Read_data_2,
    output logic        Bus_req,
    output logic        Bus_we,
    output logic [31:0] Bus_addr,
    output logic [31:0] Bus_wdata,
    output logic [3:0]  Bus_be,
    input  logic        Bus_ack,
    input  logic [31:0] Bus_rdata,
    output logic [31:0] Mem_data,
    output logic        Stall,
    output logic        Done,
    output logic        Addr_err,
    output logic        Bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nxt;

    // opcode[1:0]: 00 byte, 01 halfword, 11 word; opcode[2] selects zero-extension
    logic [1:0]  size;
    logic        req_any, misaligned, aligned_req, timeout;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [1:0]  ld_size, ld_off;
    logic        ld_uns;

    assign size        = Exe_opcode[1:0];
    assign req_any     = Mem_read | Mem_write;
    assign aligned_req = req_any & ~misaligned;
    assign Stall       = ((state == IDLE) & aligned_req) | (state == REQ);
    assign Done        = (state == DONE);

    always_comb begin
        misaligned = 1'b0;
        be_nxt     = 4'hF;
        wdata_nxt  = Read_data_2;
        case (size)
            2'b00: begin
                be_nxt    = 4'b0001 << ALU_result[1:0];
                wdata_nxt = {4{Read_data_2[7:0]}};
            end
            2'b01: begin
                misaligned = ALU_result[0];
                be_nxt     = ALU_result[1] ? 4'b1100 : 4'b0011;
                wdata_nxt  = {2{Read_data_2[15:0]}};
            end
            2'b11: misaligned = |ALU_result[1:0];
            default: ;
        endcase
    end

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: extend = d;
        endcase
    endfunction

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    // count value 254 marks the 255th REQ cycle; an ack in that cycle still wins
    assign timeout = (state == REQ) & ~Bus_ack & (tmo_cnt == 8'd254);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= 8'd0;
            Bus_err <= 1'b0;
        end else begin
            Bus_err <= timeout;
            if (state == IDLE && aligned_req)
                tmo_cnt <= 8'd0;
            else if (state == REQ && !Bus_ack)
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
    assign Bus_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aligned_req) state_nxt = REQ;
            REQ:     if (Bus_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Bus_req   <= 1'b0;
            Bus_we    <= 1'b0;
            Bus_addr  <= 32'd0;
            Bus_wdata <= 32'd0;
            Bus_be    <= 4'd0;
            Mem_data  <= 32'd0;
            Addr_err  <= 1'b0;
            ld_size   <= 2'd0;
            ld_off    <= 2'd0;
            ld_uns    <= 1'b0;
        end else begin
            Addr_err <= (state == IDLE) & req_any & misaligned;
            case (state)
                IDLE: if (aligned_req) begin
                    Bus_req   <= 1'b1;
                    Bus_we    <= Mem_write;
                    Bus_addr  <= {ALU_result[31:2], 2'b00};
                    Bus_wdata <= wdata_nxt;
                    Bus_be    <= Mem_write ? be_nxt : 4'hF;
                    ld_size   <= size;
                    ld_uns    <= Exe_opcode[2];
                    ld_off    <= ALU_result[1:0];
                end
                REQ: if (Bus_ack || timeout) begin
                    Bus_req <= 1'b0;
                    if (Bus_ack && !Bus_we)
                        Mem_data <= extend(Bus_rdata, ld_size, ld_uns, ld_off);
                end
                default: ;
            endcase
        end
    end
endmodule
